// File: rtl/cmip_pluse_sched.sv
// Delayed-pulse scheduler: trigger edges queue deadlines in a FIFO and each due deadline fires a hold-length pulse.
// Optional pulse statistics counter is enabled by defining CMIP_PLUSE_SCHED_STAT_EN.
module cmip_pluse_sched #(
    parameter int DEPTH  = 4,
    parameter int DLY_W  = 16,
    parameter int HOLD_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_sig,
    input  logic                       i_cfg_vld,
    input  logic [DLY_W-1:0]           i_cfg_dly,
    input  logic [HOLD_W-1:0]          i_cfg_hold,
    input  logic                       i_ovf_clr,
    output logic                       o_pluse,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_pend,
    output logic                       o_ovf,
    output logic                       o_cfg_err,
    output logic [15:0]                o_pulse_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              state_q;
    logic                sig_d1_q;
    logic [DLY_W-1:0]    timer_q;
    logic [DLY_W-1:0]    dly_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [DLY_W-1:0]    fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                pulse_q;
    logic                ovf_q;
    logic                cfg_err_q;

    logic                run_active;
    logic                edge_det;
    logic                fifo_full;
    logic                head_match;
    logic                do_push;
    logic                ovf_set;
    logic [DLY_W-1:0]    deadline_d;
    logic [HOLD_W-1:0]   hold_reload_d;

    assign run_active    = (state_q == ST_RUN) && i_en;
    assign edge_det      = i_sig & ~sig_d1_q;
    assign fifo_full     = (count_q == CNT_W'(DEPTH));
    assign head_match    = run_active && (count_q != '0) && (fifo_mem_q[rd_ptr_q] == timer_q);
    // A pop in the same cycle frees a slot, so a full queue still accepts the edge.
    assign do_push       = run_active && edge_det && (!fifo_full || head_match);
    assign ovf_set       = run_active && edge_det && fifo_full && !head_match;
    assign deadline_d    = timer_q + dly_q + DLY_W'(1);
    assign hold_reload_d = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);

    assign o_pluse   = pulse_q;
    assign o_busy    = (count_q != '0) || pulse_q;
    assign o_pend    = count_q;
    assign o_ovf     = ovf_q;
    assign o_cfg_err = cfg_err_q;

    // Storage needs no reset; the pointers and count define which slots are live.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            fifo_mem_q[wr_ptr_q] <= deadline_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            sig_d1_q   <= 1'b0;
            timer_q    <= '0;
            dly_q      <= '0;
            hold_q     <= HOLD_W'(1);
            hold_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pulse_q    <= 1'b0;
            ovf_q      <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            sig_d1_q  <= i_sig;
            timer_q   <= timer_q + DLY_W'(1);
            cfg_err_q <= i_cfg_vld && o_busy;
            if (i_cfg_vld && !o_busy) begin
                dly_q  <= i_cfg_dly;
                hold_q <= i_cfg_hold;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (i_ovf_clr) begin
                ovf_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_en) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!i_en) begin
                        state_q    <= ST_IDLE;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        count_q    <= '0;
                        pulse_q    <= 1'b0;
                        hold_cnt_q <= '0;
                    end else begin
                        if (do_push) begin
                            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        end
                        if (head_match) begin
                            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        end
                        if (do_push && !head_match) begin
                            count_q <= count_q + CNT_W'(1);
                        end else if (!do_push && head_match) begin
                            count_q <= count_q - CNT_W'(1);
                        end
                        // A match during an active pulse reloads the counter, merging pulses without a gap.
                        if (head_match) begin
                            pulse_q    <= 1'b1;
                            hold_cnt_q <= hold_reload_d;
                        end else if (pulse_q) begin
                            if (hold_cnt_q == '0) begin
                                pulse_q <= 1'b0;
                            end else begin
                                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CMIP_PLUSE_SCHED_STAT_EN
    logic [15:0] pulse_cnt_q;

    // A match while the output is low is exactly the cycle before a rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pulse_cnt_q <= '0;
        end else if (i_ovf_clr) begin
            pulse_cnt_q <= '0;
        end else if (head_match && !pulse_q && (pulse_cnt_q != 16'hFFFF)) begin
            pulse_cnt_q <= pulse_cnt_q + 16'd1;
        end
    end

    assign o_pulse_cnt = pulse_cnt_q;
`else
    assign o_pulse_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cmip_pluse_sched.sv
// Directed bench for cmip_pluse_sched: vector table of trigger scenarios plus hand-written multi-cycle sequences.
module tb_cmip_pluse_sched;
    localparam int DEPTH  = 4;
    localparam int DLY_W  = 16;
    localparam int HOLD_W = 8;

`ifdef CMIP_PLUSE_SCHED_STAT_EN
    localparam int EXP_STAT = 3;
`else
    localparam int EXP_STAT = 0;
`endif

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic                    i_en;
    logic                    i_sig;
    logic                    i_cfg_vld;
    logic [DLY_W-1:0]        i_cfg_dly;
    logic [HOLD_W-1:0]       i_cfg_hold;
    logic                    i_ovf_clr;
    logic                    o_pluse;
    logic                    o_busy;
    logic [$clog2(DEPTH):0]  o_pend;
    logic                    o_ovf;
    logic                    o_cfg_err;
    logic [15:0]             o_pulse_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int tcount   = 0;

    cmip_pluse_sched #(.DEPTH(DEPTH), .DLY_W(DLY_W), .HOLD_W(HOLD_W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_sig       (i_sig),
        .i_cfg_vld   (i_cfg_vld),
        .i_cfg_dly   (i_cfg_dly),
        .i_cfg_hold  (i_cfg_hold),
        .i_ovf_clr   (i_ovf_clr),
        .o_pluse     (o_pluse),
        .o_busy      (o_busy),
        .o_pend      (o_pend),
        .o_ovf       (o_ovf),
        .o_cfg_err   (o_cfg_err),
        .o_pulse_cnt (o_pulse_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int dly;
        int hold;
        bit use_cfg;
        int n_edges;
        int gap;
        int exp_first;
        int exp_high;
        int exp_rises;
        int exp_pend_max;
        int exp_ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge i_clk);
        #1;
        tcount++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst  = 1'b0;
        tcount = 0;
    endtask

    task automatic apply_cfg(input int dly, input int hold);
        i_cfg_vld  = 1'b1;
        i_cfg_dly  = DLY_W'(dly);
        i_cfg_hold = HOLD_W'(hold);
        tick();
        i_cfg_vld  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 2000 && o_busy; c++) tick();
        check(name, int'(o_busy), 0);
    endtask

    // Edge k is driven in cycle k*gap; sample index k+1 is the cycle after stimulus cycle k.
    task automatic run_seq(input int n_edges, input int gap, input int win,
                           output int first, output int high_n, output int rises,
                           output int pend_max);
        logic prev;
        prev     = 1'b0;
        first    = -1;
        high_n   = 0;
        rises    = 0;
        pend_max = 0;
        for (int k = 0; k < win; k++) begin
            i_sig = ((k % gap) == 0) && ((k / gap) < n_edges);
            tick();
            if (o_pluse) begin
                if (first < 0) first = k + 1;
                high_n++;
                if (!prev) rises++;
            end
            prev = o_pluse;
            if (int'(o_pend) > pend_max) pend_max = int'(o_pend);
        end
        i_sig = 1'b0;
    endtask

    initial begin
        int first, high_n, rises, pend_max, k, width;

        //               dly hold cfg n  gap first high rises pend ovf
        vecs[0] = '{  0,   1, 1'b0, 1, 2,   2,   1,  1,   1,   0};
        vecs[1] = '{255,  10, 1'b1, 1, 2, 257,  10,  1,   1,   0};
        vecs[2] = '{  0,   0, 1'b1, 1, 2,   2,   1,  1,   1,   0};
        vecs[3] = '{  5,   3, 1'b1, 1, 2,   7,   3,  1,   1,   0};
        vecs[4] = '{ 20,  10, 1'b1, 2, 5,  22,  15,  1,   2,   0};
        vecs[5] = '{  3,   2, 1'b1, 2, 5,   5,   4,  2,   1,   0};
        vecs[6] = '{  4,   3, 1'b1, 2, 3,   6,   6,  1,   2,   0};
        vecs[7] = '{100,   1, 1'b1, 5, 3, 102,   4,  4,   4,   1};

        i_rst = 1'b1; i_en = 1'b0; i_sig = 1'b0; i_cfg_vld = 1'b0;
        i_cfg_dly = '0; i_cfg_hold = '0; i_ovf_clr = 1'b0;
        do_reset();
        check("rst_pluse",   int'(o_pluse), 0);
        check("rst_busy",    int'(o_busy), 0);
        check("rst_pend",    int'(o_pend), 0);
        check("rst_ovf",     int'(o_ovf), 0);
        check("rst_cfg_err", int'(o_cfg_err), 0);
        check("rst_cnt",     int'(o_pulse_cnt), 0);

        i_en = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) begin
            int hold_eff, win;
            wait_idle($sformatf("v%0d_pre_idle", i));
            if (vecs[i].use_cfg) apply_cfg(vecs[i].dly, vecs[i].hold);
            hold_eff = (vecs[i].hold == 0) ? 1 : vecs[i].hold;
            win = vecs[i].dly + hold_eff * vecs[i].n_edges + vecs[i].gap * vecs[i].n_edges + 10;
            run_seq(vecs[i].n_edges, vecs[i].gap, win, first, high_n, rises, pend_max);
            $display("vec %0d dly=%0d hold=%0d edges=%0d gap=%0d -> first=%0d high=%0d rises=%0d pend_max=%0d ovf=%0d",
                     i, vecs[i].dly, vecs[i].hold, vecs[i].n_edges, vecs[i].gap,
                     first, high_n, rises, pend_max, o_ovf);
            check($sformatf("v%0d_first", i),    first,    vecs[i].exp_first);
            check($sformatf("v%0d_high", i),     high_n,   vecs[i].exp_high);
            check($sformatf("v%0d_rises", i),    rises,    vecs[i].exp_rises);
            check($sformatf("v%0d_pend_max", i), pend_max, vecs[i].exp_pend_max);
            check($sformatf("v%0d_ovf", i),      int'(o_ovf), vecs[i].exp_ovf);
            check($sformatf("v%0d_busy_end", i), int'(o_busy), 0);
        end

        // Overflow clear (also clears the statistics counter)
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        $display("ovf_clr -> ovf=%0d cnt=%0d", o_ovf, o_pulse_cnt);
        check("ovf_clr", int'(o_ovf), 0);
        check("cnt_clr", int'(o_pulse_cnt), 0);

        // Statistics: three well-separated triggers
        apply_cfg(2, 1);
        run_seq(3, 10, 40, first, high_n, rises, pend_max);
        $display("stats -> rises=%0d cnt=%0d", rises, o_pulse_cnt);
        check("stat_rises", rises, 3);
        check("stat_cnt", int'(o_pulse_cnt), EXP_STAT);

        // Config strobe while busy is rejected and leaves the delay unchanged
        wait_idle("rej_pre_idle");
        apply_cfg(50, 2);
        i_sig = 1'b1;
        tick();
        i_sig      = 1'b0;
        i_cfg_vld  = 1'b1;
        i_cfg_dly  = DLY_W'(5);
        i_cfg_hold = HOLD_W'(7);
        tick();
        i_cfg_vld = 1'b0;
        check("rej_cfg_err_hi", int'(o_cfg_err), 1);
        tick();
        check("rej_cfg_err_lo", int'(o_cfg_err), 0);
        k = 3;
        while (k < 200 && !o_pluse) begin
            tick();
            k++;
        end
        width = 0;
        while (width < 50 && o_pluse) begin
            tick();
            width++;
        end
        $display("cfg_reject -> first=%0d width=%0d", k, width);
        check("rej_first", k, 52);
        check("rej_width", width, 2);

        // Disable mid-queue while a pulse is active: flush next cycle
        wait_idle("flush_pre_idle");
        k = 0;
        while (k < 100) begin
            i_sig = (k == 0) || (k == 3);
            tick();
            k++;
            if (o_pluse) break;
        end
        i_sig = 1'b0;
        check("flush_first", k, 52);
        check("flush_pend_before", int'(o_pend), 1);
        i_en = 1'b0;
        tick();
        $display("flush -> pend=%0d pluse=%0d busy=%0d", o_pend, o_pluse, o_busy);
        check("flush_pend", int'(o_pend), 0);
        check("flush_pluse", int'(o_pluse), 0);
        check("flush_busy", int'(o_busy), 0);
        i_sig = 1'b1;
        tick();
        i_sig = 1'b0;
        tick();
        check("idle_edge_pend", int'(o_pend), 0);
        i_en = 1'b1;
        tick();
        tick();
        run_seq(0, 2, 80, first, high_n, rises, pend_max);
        check("flush_residual", rises, 0);

        // Reset mid-pulse discards all pending work
        k = 0;
        while (k < 100) begin
            i_sig = (k == 0) || (k == 3);
            tick();
            k++;
            if (o_pluse) break;
        end
        i_sig = 1'b0;
        check("rstmid_pulse_seen", int'(o_pluse), 1);
        do_reset();
        check("rstmid_pluse", int'(o_pluse), 0);
        check("rstmid_pend", int'(o_pend), 0);
        check("rstmid_busy", int'(o_busy), 0);
        run_seq(0, 2, 80, first, high_n, rises, pend_max);
        $display("reset_mid -> residual rises=%0d", rises);
        check("rstmid_residual", rises, 0);

        // Timer wrap: trigger with the timer near 16'hFFF0
        do_reset();
        apply_cfg(40, 1);
        while (tcount < 32'hFFF0) tick();
        run_seq(1, 2, 60, first, high_n, rises, pend_max);
        $display("wrap -> first=%0d high=%0d", first, high_n);
        check("wrap_first", first, 42);
        check("wrap_high", high_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
